// File: rtl/wash_phase_timer_if.sv
// Phase/timeout bundle between the wash controller (master) and wash_phase_timer (slave).
interface wash_phase_timer_if #(
    parameter int CNT_W = 8
);
    logic             soap_wash;
    logic             water_wash;
    logic             motor_on;
    logic             drain_value_on;
    logic             door_close;
    logic             cycle_timeout;
    logic             spin_timeout;
    logic [CNT_W-1:0] remaining;
    logic             busy;

    modport master (
        output soap_wash, water_wash, motor_on, drain_value_on, door_close,
        input  cycle_timeout, spin_timeout, remaining, busy
    );

    modport slave (
        input  soap_wash, water_wash, motor_on, drain_value_on, door_close,
        output cycle_timeout, spin_timeout, remaining, busy
    );
endinterface

// File: rtl/wash_phase_timer.sv
// Counts soap/rinse/spin phase durations and raises the controller's timeout inputs.
// Optional door pause: define WASH_PHASE_TIMER_PAUSE_EN.
module wash_phase_timer #(
    parameter int TICK_DIV    = 4,
    parameter int SOAP_TICKS  = 6,
    parameter int RINSE_TICKS = 4,
    parameter int SPIN_TICKS  = 5,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    wash_phase_timer_if.slave  bus
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WASH_RUN = 3'd1;
    localparam logic [2:0] WASH_EXP = 3'd2;
    localparam logic [2:0] SPIN_RUN = 3'd3;
    localparam logic [2:0] SPIN_EXP = 3'd4;

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] remaining, remaining_nxt;
    logic [PS_W-1:0]  prescaler, prescaler_nxt;
    logic             soap_sel, soap_sel_nxt;
    logic             phase_in;
    logic             tick;
    logic             hold;

`ifdef WASH_PHASE_TIMER_PAUSE_EN
    // An open door freezes the running phase; aborts are still honoured.
    assign hold = !bus.door_close;
`else
    logic unused_door_close;
    assign unused_door_close = bus.door_close;
    assign hold              = 1'b0;
`endif

    // The wash input that started the current phase is the one that keeps it alive.
    assign phase_in = soap_sel ? bus.soap_wash : bus.water_wash;
    assign tick     = (prescaler == PS_W'(TICK_DIV - 1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_nxt     = state;
        remaining_nxt = remaining;
        prescaler_nxt = prescaler;
        soap_sel_nxt  = soap_sel;

        case (state)
            IDLE: begin
                if (bus.motor_on && bus.soap_wash) begin
                    state_nxt     = WASH_RUN;
                    remaining_nxt = CNT_W'(SOAP_TICKS);
                    prescaler_nxt = '0;
                    soap_sel_nxt  = 1'b1;
                end else if (bus.motor_on && bus.water_wash) begin
                    state_nxt     = WASH_RUN;
                    remaining_nxt = CNT_W'(RINSE_TICKS);
                    prescaler_nxt = '0;
                    soap_sel_nxt  = 1'b0;
                end else if (bus.motor_on && bus.drain_value_on &&
                             !bus.soap_wash && !bus.water_wash) begin
                    state_nxt     = SPIN_RUN;
                    remaining_nxt = CNT_W'(SPIN_TICKS);
                    prescaler_nxt = '0;
                end
            end

            WASH_RUN, SPIN_RUN: begin
                if (!bus.motor_on || (state == WASH_RUN && !phase_in)) begin
                    state_nxt     = IDLE;
                    remaining_nxt = '0;
                    prescaler_nxt = '0;
                end else if (!hold) begin
                    if (tick) begin
                        prescaler_nxt = '0;
                        if (remaining <= CNT_W'(1)) begin
                            remaining_nxt = '0;
                            state_nxt     = (state == WASH_RUN) ? WASH_EXP : SPIN_EXP;
                        end else begin
                            remaining_nxt = remaining - CNT_W'(1);
                        end
                    end else begin
                        prescaler_nxt = prescaler + PS_W'(1);
                    end
                end
            end

            WASH_EXP: begin
                if (!phase_in) state_nxt = IDLE;
            end

            SPIN_EXP: begin
                if (!bus.motor_on) state_nxt = IDLE;
            end

            default: begin
                state_nxt     = IDLE;
                remaining_nxt = '0;
                prescaler_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            prescaler <= '0;
            soap_sel  <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            prescaler <= prescaler_nxt;
            soap_sel  <= soap_sel_nxt;
        end
    end

    assign bus.cycle_timeout = (state == WASH_EXP);
    assign bus.spin_timeout  = (state == SPIN_EXP);
    assign bus.busy          = (state != IDLE);
    assign bus.remaining     = remaining;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Self-checking bench for wash_phase_timer: per-cycle phase model plus directed literal checks.
module tb_wash_phase_timer;

    localparam int TD    = 4;
    localparam int SOAP  = 6;
    localparam int RINSE = 4;
    localparam int SPIN  = 5;
    localparam int CW    = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wash_phase_timer_if #(.CNT_W(CW)) bus ();
    wash_phase_timer_if #(.CNT_W(CW)) bus1 ();

    wash_phase_timer #(
        .TICK_DIV(TD), .SOAP_TICKS(SOAP), .RINSE_TICKS(RINSE),
        .SPIN_TICKS(SPIN), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    // Second instance exercises the one-tick-per-cycle corner.
    wash_phase_timer #(
        .TICK_DIV(1), .SOAP_TICKS(3), .RINSE_TICKS(2),
        .SPIN_TICKS(2), .CNT_W(CW)
    ) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    assign bus1.soap_wash      = bus.soap_wash;
    assign bus1.water_wash     = bus.water_wash;
    assign bus1.motor_on       = bus.motor_on;
    assign bus1.drain_value_on = bus.drain_value_on;
    assign bus1.door_close     = bus.door_close;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 running, 2 expired; kind 0 soap, 1 rinse, 2 spin.
    // A phase of n ticks expires once n*TD counting edges have elapsed since load.
    int m_mode = 0, m_kind = 0, m_n = 0, m_active = 0;

    function automatic bit kind_input(int kind);
        if (kind == 0) return bus.soap_wash;
        if (kind == 1) return bus.water_wash;
        return bus.motor_on;
    endfunction

    task automatic model_step();
        bit paused;
`ifdef WASH_PHASE_TIMER_PAUSE_EN
        paused = !bus.door_close;
`else
        paused = 1'b0;
`endif
        if (reset) begin
            m_mode = 0; m_active = 0;
        end else if (m_mode == 0) begin
            m_active = 0;
            if (bus.motor_on && bus.soap_wash) begin
                m_mode = 1; m_kind = 0; m_n = SOAP;
            end else if (bus.motor_on && bus.water_wash) begin
                m_mode = 1; m_kind = 1; m_n = RINSE;
            end else if (bus.motor_on && bus.drain_value_on) begin
                m_mode = 1; m_kind = 2; m_n = SPIN;
            end
        end else if (m_mode == 1) begin
            if (!bus.motor_on || !kind_input(m_kind)) m_mode = 0;
            else if (!paused) begin
                m_active++;
                if (m_active >= m_n * TD) m_mode = 2;
            end
        end else begin
            if (!kind_input(m_kind)) m_mode = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("m_busy", int'(bus.busy), int'(m_mode != 0));
            check("m_remaining", int'(bus.remaining), (m_mode == 1) ? m_n - m_active / TD : 0);
            check("m_cycle_timeout", int'(bus.cycle_timeout), int'(m_mode == 2 && m_kind != 2));
            check("m_spin_timeout", int'(bus.spin_timeout), int'(m_mode == 2 && m_kind == 2));
        end
    end

    task automatic set_in(input bit s, input bit w, input bit m, input bit d);
        bus.soap_wash      = s;
        bus.water_wash     = w;
        bus.motor_on       = m;
        bus.drain_value_on = d;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_gap();
        set_in(0, 0, 0, 0);
        cyc(2);
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0);
        bus.door_close = 1'b1;
        cyc(2);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_remaining", int'(bus.remaining), 0);
        check("rst_cycle_timeout", int'(bus.cycle_timeout), 0);
        check("rst_spin_timeout", int'(bus.spin_timeout), 0);
        reset = 1'b0;
        cyc(1);

        // Soap phase: 6 ticks of 4 cycles
        set_in(1, 0, 1, 0);
        cyc(1);
        check("soap_load_rem", int'(bus.remaining), 6);
        check("soap_load_busy", int'(bus.busy), 1);
        check("div1_load_rem", int'(bus1.remaining), 3);
        cyc(2);
        check("div1_ct_k2", int'(bus1.cycle_timeout), 0);
        cyc(1);
        check("div1_ct_k3", int'(bus1.cycle_timeout), 1);
        cyc(1);
        check("soap_rem_k4", int'(bus.remaining), 5);
        cyc(19);
        check("soap_ct_k23", int'(bus.cycle_timeout), 0);
        check("soap_rem_k23", int'(bus.remaining), 1);
        cyc(1);
        check("soap_ct_k24", int'(bus.cycle_timeout), 1);
        check("soap_rem_k24", int'(bus.remaining), 0);
        set_in(0, 0, 1, 0);
        cyc(1);
        check("soap_exit_ct", int'(bus.cycle_timeout), 0);
        check("soap_exit_busy", int'(bus.busy), 0);
        idle_gap();

        // Rinse phase: 16 cycles
        set_in(0, 1, 1, 0);
        cyc(1);
        check("rinse_load_rem", int'(bus.remaining), 4);
        cyc(15);
        check("rinse_ct_k15", int'(bus.cycle_timeout), 0);
        cyc(1);
        check("rinse_ct_k16", int'(bus.cycle_timeout), 1);
        idle_gap();

        // Soap wins over rinse
        set_in(1, 1, 1, 0);
        cyc(1);
        check("prio_load_rem", int'(bus.remaining), 6);
        cyc(23);
        check("prio_ct_k23", int'(bus.cycle_timeout), 0);
        cyc(1);
        check("prio_ct_k24", int'(bus.cycle_timeout), 1);
        idle_gap();

        // Spin: 20 cycles, held until motor drops
        set_in(0, 0, 1, 1);
        cyc(1);
        check("spin_load_rem", int'(bus.remaining), 5);
        cyc(19);
        check("spin_st_k19", int'(bus.spin_timeout), 0);
        cyc(1);
        check("spin_st_k20", int'(bus.spin_timeout), 1);
        cyc(3);
        check("spin_st_hold", int'(bus.spin_timeout), 1);
        set_in(0, 0, 0, 1);
        cyc(1);
        check("spin_exit_st", int'(bus.spin_timeout), 0);
        check("spin_exit_busy", int'(bus.busy), 0);
        idle_gap();

        // Abort 10 cycles into soap
        set_in(1, 0, 1, 0);
        cyc(11);
        set_in(0, 0, 1, 0);
        cyc(1);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_rem", int'(bus.remaining), 0);
        check("abort_ct", int'(bus.cycle_timeout), 0);
        idle_gap();

        // Reset 12 cycles into spin
        set_in(0, 0, 1, 1);
        cyc(13);
        reset = 1'b1;
        cyc(1);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_rem", int'(bus.remaining), 0);
        check("midrst_st", int'(bus.spin_timeout), 0);
        check("midrst_ct", int'(bus.cycle_timeout), 0);
        reset = 1'b0;
        idle_gap();

        // Door open for 8 cycles mid-soap
        set_in(1, 0, 1, 0);
        cyc(5);
        bus.door_close = 1'b0;
        cyc(8);
        bus.door_close = 1'b1;
`ifdef WASH_PHASE_TIMER_PAUSE_EN
        cyc(19);
        check("pause_ct_k31", int'(bus.cycle_timeout), 0);
        cyc(1);
        check("pause_ct_k32", int'(bus.cycle_timeout), 1);
`else
        cyc(11);
        check("pause_ct_k23", int'(bus.cycle_timeout), 0);
        cyc(1);
        check("pause_ct_k24", int'(bus.cycle_timeout), 1);
`endif
        idle_gap();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
